// File: rtl/bch_ecc_loader.sv
// Reads the stored BCH helper-data bytes back from byte-wide memory and presents
// {data, ecc} as one codeword over a valid/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; data word latched on acceptance
// S_READ  | one memory read per cycle, LP_NBYTES reads back to back
// S_DRAIN | waiting for the remaining read responses to be captured
// S_VALID | codeword presented and held until the consumer takes it
module bch_ecc_loader #(
    parameter int C_DATA_BITS     = 4,
    parameter int C_ECC_BITS      = 20,
    parameter int C_MEM_ADDR_SIZE = 10,
    parameter int C_MEM_DATA_SIZE = 8,
    parameter int C_BASE_ADDR     = 0,
    parameter int C_MEM_LAT       = 1
) (
    input  logic                              I_clk,
    input  logic                              I_rstn,
    input  logic                              I_start,
    input  logic [C_DATA_BITS-1:0]            I_data,
    output logic [C_MEM_ADDR_SIZE-1:0]        O_mem_raddr,
    output logic                              O_ren,
    input  logic [C_MEM_DATA_SIZE-1:0]        I_mem_rdata,
    output logic [C_DATA_BITS+C_ECC_BITS-1:0] O_codeword,
    output logic                              O_valid,
    input  logic                              I_ready,
    output logic                              O_busy
);

    localparam int LP_NBYTES = (C_ECC_BITS + C_MEM_DATA_SIZE - 1) / C_MEM_DATA_SIZE;
    localparam int LP_CW     = (LP_NBYTES > 1) ? $clog2(LP_NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [LP_CW-1:0]             rd_left_q;
    logic [LP_CW-1:0]             cap_idx_q;
    logic [C_MEM_ADDR_SIZE-1:0]   raddr_q;
    logic [C_MEM_LAT-1:0]         ren_pipe_q;
    logic [C_DATA_BITS-1:0]       data_q;
    logic [C_ECC_BITS-1:0]        ecc_q;
    logic [C_ECC_BITS-1:0]        cap_mask;
    logic [C_ECC_BITS-1:0]        rdata_rep;
    logic                         start_acc;
    logic                         issue;
    logic                         cap_en;
    logic                         cap_last;

    assign issue     = (state_q == S_READ);
    assign start_acc = (state_q == S_IDLE) && I_start;
    assign cap_en    = ren_pipe_q[C_MEM_LAT-1];
    assign cap_last  = cap_en && (cap_idx_q == LP_CW'(LP_NBYTES - 1));

    // Each ECC bit knows which byte slot and which byte lane feeds it; bits of
    // the last byte above C_ECC_BITS simply have no destination.
    for (genvar b = 0; b < C_ECC_BITS; b++) begin : g_bit
        assign rdata_rep[b] = I_mem_rdata[b % C_MEM_DATA_SIZE];
        assign cap_mask[b]  = cap_en && (cap_idx_q == LP_CW'(b / C_MEM_DATA_SIZE));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (I_start)          state_d = S_READ;
            S_READ:  if (rd_left_q == '0)  state_d = S_DRAIN;
            S_DRAIN: if (cap_last)         state_d = S_VALID;
            S_VALID: if (I_ready)          state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            state_q    <= S_IDLE;
            rd_left_q  <= '0;
            cap_idx_q  <= '0;
            raddr_q    <= '0;
            ren_pipe_q <= '0;
            data_q     <= '0;
            ecc_q      <= '0;
        end else begin
            state_q <= state_d;
            // Delayed read enable marks the cycle each response is on the bus.
            ren_pipe_q[0] <= issue;
            for (int i = 1; i < C_MEM_LAT; i++) begin
                ren_pipe_q[i] <= ren_pipe_q[i-1];
            end
            if (start_acc) begin
                data_q    <= I_data;
                ecc_q     <= '0;
                rd_left_q <= LP_CW'(LP_NBYTES - 1);
                cap_idx_q <= '0;
                raddr_q   <= C_MEM_ADDR_SIZE'(C_BASE_ADDR);
            end
            if (issue) begin
                raddr_q   <= raddr_q + C_MEM_ADDR_SIZE'(1);
                rd_left_q <= rd_left_q - LP_CW'(1);
            end
            if (cap_en) begin
                ecc_q     <= (ecc_q & ~cap_mask) | (rdata_rep & cap_mask);
                cap_idx_q <= cap_idx_q + LP_CW'(1);
            end
        end
    end

    assign O_ren       = issue;
    assign O_mem_raddr = issue ? raddr_q : '0;
    assign O_valid     = (state_q == S_VALID);
    assign O_busy      = (state_q != S_IDLE);
    assign O_codeword  = {data_q, ecc_q};

endmodule

// File: tb/tb_bch_ecc_loader.sv
// Directed bench for bch_ecc_loader: default, long-latency and wrapping-address
// instances sharing one byte-wide memory model.
module tb_bch_ecc_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  data;
    logic [2:0]  start_v;
    logic [2:0]  ready_v;
    logic [1:0]  sel;

    logic [9:0]  raddr_a, raddr_b, raddr_c;
    logic        ren_a, ren_b, ren_c;
    logic [7:0]  rd_a, rd_b, rd_c, p1_b, p2_b;
    logic [23:0] cw_a, cw_b, cw_c;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;

    logic        cur_ren, cur_valid, cur_busy;
    logic [9:0]  cur_addr;
    logic [23:0] cur_cw;

    logic [7:0]  mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bch_ecc_loader u_dut_a (
        .I_clk(clk), .I_rstn(rstn), .I_start(start_v[0]), .I_data(data),
        .O_mem_raddr(raddr_a), .O_ren(ren_a), .I_mem_rdata(rd_a),
        .O_codeword(cw_a), .O_valid(valid_a), .I_ready(ready_v[0]), .O_busy(busy_a)
    );

    bch_ecc_loader #(.C_MEM_LAT(3)) u_dut_b (
        .I_clk(clk), .I_rstn(rstn), .I_start(start_v[1]), .I_data(data),
        .O_mem_raddr(raddr_b), .O_ren(ren_b), .I_mem_rdata(rd_b),
        .O_codeword(cw_b), .O_valid(valid_b), .I_ready(ready_v[1]), .O_busy(busy_b)
    );

    bch_ecc_loader #(.C_BASE_ADDR(1022)) u_dut_c (
        .I_clk(clk), .I_rstn(rstn), .I_start(start_v[2]), .I_data(data),
        .O_mem_raddr(raddr_c), .O_ren(ren_c), .I_mem_rdata(rd_c),
        .O_codeword(cw_c), .O_valid(valid_c), .I_ready(ready_v[2]), .O_busy(busy_c)
    );

    // Memory: one-cycle latency for a and c, three-cycle latency for b.
    always @(posedge clk) begin
        rd_a <= mem[raddr_a];
        rd_c <= mem[raddr_c];
        p1_b <= mem[raddr_b];
        p2_b <= p1_b;
        rd_b <= p2_b;
    end

    always_comb begin
        cur_ren = ren_a; cur_addr = raddr_a; cur_cw = cw_a; cur_valid = valid_a; cur_busy = busy_a;
        case (sel)
            2'd1: begin
                cur_ren = ren_b; cur_addr = raddr_b; cur_cw = cw_b; cur_valid = valid_b; cur_busy = busy_b;
            end
            2'd2: begin
                cur_ren = ren_c; cur_addr = raddr_c; cur_cw = cw_c; cur_valid = valid_c; cur_busy = busy_c;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts a load on the selected instance and follows it to O_valid (not accepted).
    task automatic run_load(input logic [1:0] s, input logic [3:0] d, input bit hold,
                            input int exp_vcyc, input logic [9:0] a0, input logic [9:0] a1,
                            input logic [9:0] a2, input logic [23:0] exp_cw);
        int c;
        logic [9:0] exp_a [3];
        exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
        sel = s;
        @(negedge clk);
        data = d;
        start_v[s] = 1'b1;
        c = 0;
        while (c < 30) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                if (!hold) start_v[s] = 1'b0;
                data = ~d;
            end
            if (c <= 3) begin
                check("ren_issue", 32'(cur_ren), 32'd1);
                check("raddr", 32'(cur_addr), 32'(exp_a[c-1]));
            end else if (cur_valid) begin
                break;
            end else begin
                check("ren_after_issue", 32'(cur_ren), 32'd0);
            end
        end
        check("valid_cycle", 32'(c), 32'(exp_vcyc));
        check("codeword", 32'(cur_cw), 32'(exp_cw));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ren_cnt;
        int cw_changes;
        rstn = 1'b0; start_v = '0; ready_v = '0; data = '0; sel = 2'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hF7;
        mem[1022] = 8'h5A; mem[1023] = 8'hC3;

        // Reset
        repeat (2) begin
            @(negedge clk);
            check("rst_ren", 32'(ren_a), 32'd0);
            check("rst_valid", 32'(valid_a), 32'd0);
            check("rst_busy", 32'(busy_a), 32'd0);
            check("rst_raddr", 32'(raddr_a), 32'd0);
            check("rst_valid_b", 32'(valid_b), 32'd0);
            check("rst_busy_c", 32'(busy_c), 32'd0);
        end
        rstn = 1'b1;

        // Basic load, then backpressure with a start pulse during the stall
        run_load(2'd0, 4'h9, 1'b0, 5, 10'd0, 10'd1, 10'd2, 24'h973CA5);
        ren_cnt = 0; cw_changes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_v[0] = (i == 3);
            if (cur_ren) ren_cnt++;
            if (cur_cw !== 24'h973CA5) cw_changes++;
        end
        start_v[0] = 1'b0;
        check("stall_ren_count", 32'(ren_cnt), 32'd0);
        check("stall_cw_changes", 32'(cw_changes), 32'd0);
        check("stall_valid", 32'(cur_valid), 32'd1);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        check("accept_valid", 32'(cur_valid), 32'd0);
        check("accept_busy", 32'(cur_busy), 32'd0);
        @(negedge clk);
        check("no_queued_start", 32'(cur_busy), 32'd0);

        // Latency 3, with ready already high before valid
        ready_v[1] = 1'b1;
        run_load(2'd1, 4'h9, 1'b0, 7, 10'd0, 10'd1, 10'd2, 24'h973CA5);
        @(negedge clk);
        ready_v[1] = 1'b0;
        check("lat3_accept_valid", 32'(cur_valid), 32'd0);
        check("lat3_accept_busy", 32'(cur_busy), 32'd0);

        // Address wrap from 1022
        run_load(2'd2, 4'h5, 1'b0, 5, 10'd1022, 10'd1023, 10'd0, 24'h55C35A);
        ready_v[2] = 1'b1;
        @(negedge clk);
        ready_v[2] = 1'b0;
        check("wrap_accept_valid", 32'(cur_valid), 32'd0);

        // Reset during the second read, then restart with new contents
        sel = 2'd0;
        @(negedge clk);
        data = 4'h6;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("midrst_ren", 32'(cur_ren), 32'd1);
        check("midrst_raddr", 32'(cur_addr), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(cur_busy), 32'd0);
        check("midrst_ren_off", 32'(cur_ren), 32'd0);
        rstn = 1'b1;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        run_load(2'd0, 4'hB, 1'b1, 5, 10'd0, 10'd1, 10'd2, 24'hB32211);

        // Held start relaunches one cycle after returning to IDLE
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        check("held_idle_busy", 32'(cur_busy), 32'd0);
        check("held_idle_valid", 32'(cur_valid), 32'd0);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("held_restart_ren", 32'(cur_ren), 32'd1);
        check("held_restart_raddr", 32'(cur_addr), 32'd0);
        repeat (8) @(negedge clk);
        check("held_second_valid", 32'(cur_valid), 32'd1);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        check("final_busy", 32'(cur_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
